// File: rtl/mpadder_iter.sv
// Iterative multi-precision adder/subtractor: one CHUNK-bit limb per cycle, LSB limb first.
// Operands are latched on the accepting edge; result/zero/borrow change only on completion.
module mpadder_iter #(
  parameter int WIDTH = 1027,
  parameter int CHUNK = 257
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             done,
  output logic             busy,
  output logic             ready,
  output logic             zero,
  output logic             borrow
);

  localparam int NCHUNK = (WIDTH + CHUNK) / CHUNK;
  localparam int P      = NCHUNK * CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int SW     = (NCHUNK > 1) ? P - CHUNK : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  generate
    if (WIDTH < 1 || CHUNK < 1) begin : g_bad_param
      $error("mpadder_iter: WIDTH and CHUNK must both be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [P-1:0]     r_a;
  logic [P-1:0]     r_b;
  logic [SW-1:0]    r_sum;
  logic             r_carry;
  logic             r_sub;
  logic [CNT_W-1:0] r_cnt;

  logic [CHUNK:0]   w_limb;
  logic [SW-1:0]    w_sum_next;
  logic [P-1:0]     w_full;
  logic [WIDTH:0]   w_res;
  logic [P-1:0]     w_a_pad;
  logic [P-1:0]     w_b_pad;

  assign w_limb  = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
  assign w_a_pad = {{(P-WIDTH){1'b0}}, in_a};
  // Subtraction: invert B over the whole padded width; the +1 arrives as the limb-0 carry-in.
  assign w_b_pad = {{(P-WIDTH){1'b0}}, in_b} ^ {P{subtract}};
  assign w_res   = w_full[WIDTH:0];
  assign ready   = ~busy;

  // r_sum holds the completed lower limbs; the limb being added now forms the top of w_full.
  generate
    if (NCHUNK > 2) begin : g_multi
      assign w_sum_next = {w_limb[CHUNK-1:0], r_sum[SW-1:CHUNK]};
      assign w_full     = {w_limb[CHUNK-1:0], r_sum};
    end else if (NCHUNK == 2) begin : g_two
      assign w_sum_next = w_limb[CHUNK-1:0];
      assign w_full     = {w_limb[CHUNK-1:0], r_sum};
    end else begin : g_one
      assign w_sum_next = '0;
      assign w_full     = w_limb[CHUNK-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_cnt   <= '0;
      result  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      zero    <= 1'b0;
      borrow  <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_sum   <= w_sum_next;
          r_carry <= w_limb[CHUNK];
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            result  <= w_res;
            zero    <= ~|w_res;
            borrow  <= r_sub & w_res[WIDTH];
          end
        end
        default: begin
          // IDLE and DONE accept identically, which gives back-to-back issue.
          done <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_a     <= w_a_pad;
            r_b     <= w_b_pad;
            r_sub   <= subtract;
            r_carry <= subtract;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mpadder_iter.md
Name: mpadder_iter

Overview:
- Parametrised iterative multi-precision adder/subtractor for the big-integer datapath. Successor to the fixed 1027-bit, two-pass adder.
- Operand width, limb width and therefore cycle count are parameters. Adds a busy/ready handshake, back-to-back issue, and zero and borrow flags.
- Sits between the operand RAM/registers and the Montgomery/modular-reduction units, which use it for A+B and A−B.

Parameters:
- WIDTH, 1027, operand width in bits; result is WIDTH+1 bits.
- CHUNK, 257, limb width in bits processed per cycle by the single CHUNK-bit adder.
- NCHUNK, derived = ceil((WIDTH+1)/CHUNK) (4 at defaults), number of limb cycles; localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled on clk when ready=1.
- subtract  in  1  0: A+B, 1: A−B; latched with the operands.
- in_a  in  WIDTH  operand A, unsigned; sampled only on the accepting edge.
- in_b  in  WIDTH  operand B, unsigned; sampled only on the accepting edge.
- result  out  WIDTH+1  sum, or two's-complement difference.
- done  out  1  one-cycle pulse; result and flags valid.
- busy  out  1  high while limbs are in flight.
- ready  out  1  equals ~busy; start is accepted only when ready=1.
- zero  out  1  result == 0; valid with done.
- borrow  out  1  for subtract, 1 when A < B (equals result[WIDTH]); 0 for add.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE; result, zero, borrow, done, busy all 0; ready=1.
  - Internal operand, sum and carry registers cleared.
- Arithmetic:
  - Operands are zero-extended to P = NCHUNK*CHUNK bits.
  - Add: result = (A + B) mod 2^(WIDTH+1).
  - Subtract: B is inverted over all P bits and the limb-0 carry-in is 1, giving result = (A − B) mod 2^(WIDTH+1).
  - result is bits [WIDTH:0] of the P-bit sum; upper padding bits are discarded.
- States:
  - IDLE: ready=1. On start=1: latch padded A, padded B (inverted if subtract), subtract, carry=subtract, limb counter=0; go to RUN. Otherwise stay.
  - RUN: busy=1. Each edge adds limb[cnt] of A and B plus the carry register; the CHUNK-bit sum shifts into the top of the P-bit sum register (LSB limb first); carry-out goes to the carry register; cnt increments. On the edge where cnt = NCHUNK−1, go to DONE and register done=1.
  - DONE: one cycle. done=1, busy=0, ready=1. start here is accepted exactly as in IDLE (back-to-back issue), going to RUN; otherwise go to IDLE.
- Latency:
  - Accepting edge at t0 → done high in the cycle after edge t0+NCHUNK.
  - Issue interval is NCHUNK+1 cycles when start is held high.
- Output holding:
  - result, zero and borrow are updated only on the edge that enters DONE.
  - They hold stable until the next completion, including through IDLE and during the following RUN.
- Inputs: in_a, in_b and subtract are don't-care outside the accepting edge. Changing them during RUN must not affect the result.
- start during RUN: ignored; not queued, no error.
- Reset asserted mid-RUN: immediate abort to the reset values; no done pulse is produced for the aborted operation.
- Boundaries:
  - A=B=0 add gives zero=1.
  - A=B subtract gives zero=1, borrow=0.
  - A=2^WIDTH−1 plus B=2^WIDTH−1 gives result[WIDTH]=1.
  - Carry must propagate across every limb boundary, including into the padding limb.
- NCHUNK=1 is legal: RUN lasts one cycle.
- An elaboration-time check fails if CHUNK < 1 or WIDTH < 1.

Test Plan:
- Defaults, A=2^1027−1, B=1, add → done exactly 4 cycles after accept; result=2^1027 (bit 1027 set, rest 0); zero=0; borrow=0; no intermediate done.
- Defaults, A=5, B=7, subtract → result = 2^1028−2 (all ones except bit 0); borrow=1. Then A=B=0x1234 subtract → result=0, zero=1, borrow=0.
- Carry ripple: A = 2^257−1 (limb 0 all ones), B=1, add → result=2^257, proving the limb-0→1 carry. Repeat at bits 514 and 771.
- start held high with 3 different operand pairs presented on successive accepting edges → accepts every 5 cycles; 3 done pulses; each result matches its own operands. Operands toggled randomly during RUN → no effect.
- Reset asserted 2 cycles into RUN → busy=0, done=0, result=0 immediately (asynchronously). Next op A=1, B=1 add after release → result=2 with normal latency.
- Parameter sweep WIDTH∈{8,31,64}, CHUNK∈{1,8,13,64}, 2000 random add/sub ops per setting vs a reference model → exact result/zero/borrow; latency = ceil((WIDTH+1)/CHUNK).
